// File: rtl/quick_spi_arbiter_if.sv
// Bundle between the requesters, the arbiter and one quick_spi_hard master.
// The arbiter uses the slave modport; the requester/master side uses master.
interface quick_spi_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int OUT_W   = 16,
  parameter int IN_W    = 8,
  parameter int SLAVE_W = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();

  // Requester side
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_operation;
  logic [NUM_REQ*SLAVE_W-1:0] req_slave;
  logic [NUM_REQ*OUT_W-1:0]   req_wdata;

  // Completion side
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic [IN_W-1:0]            rsp_data;
  logic                       rsp_error;
  logic                       busy;

  // SPI master side
  logic                       spi_enable;
  logic                       spi_start_transaction;
  logic                       spi_operation;
  logic [SLAVE_W-1:0]         spi_slave;
  logic [OUT_W-1:0]           spi_outgoing_data;
  logic                       spi_end_of_transaction;
  logic [IN_W-1:0]            spi_incoming_data;

  modport slave (
    input  req_valid, req_operation, req_slave, req_wdata,
           spi_end_of_transaction, spi_incoming_data,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, busy,
           spi_enable, spi_start_transaction, spi_operation, spi_slave,
           spi_outgoing_data
  );

  modport master (
    output req_valid, req_operation, req_slave, req_wdata,
           spi_end_of_transaction, spi_incoming_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, busy,
           spi_enable, spi_start_transaction, spi_operation, spi_slave,
           spi_outgoing_data
  );

endinterface

// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one SPI master.
// One transaction at a time: grant, start pulse, wait for end (or time out),
// one-cycle completion pulse. Every output comes straight from a register.
module quick_spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OUT_W          = 16,
  parameter int IN_W           = 8,
  parameter int SLAVE_W        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                clk,
  input logic                reset,
  quick_spi_arbiter_if.slave bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} state_t;

  state_t               r_state, w_state;
  logic [ID_W-1:0]      r_last_grant, w_last_grant;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [NUM_REQ-1:0]   r_req_ready, w_req_ready;
  logic                 r_spi_start, w_spi_start;
  logic                 r_spi_enable, w_spi_enable;
  logic                 r_spi_op, w_spi_op;
  logic [SLAVE_W-1:0]   r_spi_slave, w_spi_slave;
  logic [OUT_W-1:0]     r_spi_wdata, w_spi_wdata;
  logic                 r_rsp_valid, w_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id, w_rsp_id;
  logic [IN_W-1:0]      r_rsp_data, w_rsp_data;
  logic                 r_rsp_error, w_rsp_error;
  logic                 r_busy, w_busy;

  logic                 w_found;
  logic [ID_W-1:0]      w_winner;
  logic [ID_W-1:0]      w_idx;
  logic [SLAVE_W-1:0]   w_slave_arr [NUM_REQ];
  logic [OUT_W-1:0]     w_wdata_arr [NUM_REQ];

  // Unpack the per-requester slave codes and write data
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_slave_arr[g] = bus.req_slave[g*SLAVE_W +: SLAVE_W];
    assign w_wdata_arr[g] = bus.req_wdata[g*OUT_W +: OUT_W];
  end

  // Round robin: first valid requester after the last grant, with wrap-around
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Next-state and next-output logic; registers hold unless a state changes them
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_last_grant = r_last_grant;
    w_req_ready  = '0;
    w_spi_start  = 1'b0;
    w_spi_enable = 1'b1;
    w_spi_op     = r_spi_op;
    w_spi_slave  = r_spi_slave;
    w_spi_wdata  = r_spi_wdata;
    w_rsp_valid  = 1'b0;
    w_rsp_id     = r_rsp_id;
    w_rsp_data   = r_rsp_data;
    w_rsp_error  = r_rsp_error;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_spi_op              = bus.req_operation[w_winner];
          w_spi_slave           = w_slave_arr[w_winner];
          w_spi_wdata           = w_wdata_arr[w_winner];
          w_last_grant          = w_winner;
          w_req_ready[w_winner] = 1'b1;
          w_spi_start           = 1'b1;
          w_state               = ST_START;
        end
      end
      ST_START: begin
        w_cnt   = '0;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        // End of transaction has priority over a timeout on the same cycle
        if (bus.spi_end_of_transaction) begin
          w_rsp_data  = bus.spi_incoming_data;
          w_rsp_error = 1'b0;
          w_rsp_id    = r_last_grant;
          w_rsp_valid = 1'b1;
          w_state     = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          // Abort: drop enable for the DONE cycle so the master resets itself
          w_rsp_data   = '0;
          w_rsp_error  = 1'b1;
          w_rsp_id     = r_last_grant;
          w_rsp_valid  = 1'b1;
          w_spi_enable = 1'b0;
          w_state      = ST_DONE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= ID_LAST;
      r_req_ready  <= '0;
      r_spi_start  <= 1'b0;
      r_spi_enable <= 1'b1;
      r_spi_op     <= 1'b0;
      r_spi_slave  <= '0;
      r_spi_wdata  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_rsp_error  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_last_grant <= w_last_grant;
      r_req_ready  <= w_req_ready;
      r_spi_start  <= w_spi_start;
      r_spi_enable <= w_spi_enable;
      r_spi_op     <= w_spi_op;
      r_spi_slave  <= w_spi_slave;
      r_spi_wdata  <= w_spi_wdata;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_id     <= w_rsp_id;
      r_rsp_data   <= w_rsp_data;
      r_rsp_error  <= w_rsp_error;
      r_busy       <= w_busy;
    end
  end

  assign bus.req_ready             = r_req_ready;
  assign bus.spi_start_transaction = r_spi_start;
  assign bus.spi_enable            = r_spi_enable;
  assign bus.spi_operation         = r_spi_op;
  assign bus.spi_slave             = r_spi_slave;
  assign bus.spi_outgoing_data     = r_spi_wdata;
  assign bus.rsp_valid             = r_rsp_valid;
  assign bus.rsp_id                = r_rsp_id;
  assign bus.rsp_data              = r_rsp_data;
  assign bus.rsp_error             = r_rsp_error;
  assign bus.busy                  = r_busy;

endmodule
